// File: rtl/mips_sopc_if.sv
// rtl/mips_sopc_if.sv - instruction fetch bus between the core and the instruction ROM
interface mips_sopc_if;
  logic [31:0] pc;
  logic [31:0] instr;

  modport master (output pc, input instr);
  modport slave (input pc, output instr);
endinterface

// File: rtl/mips_sopc.sv
// rtl/mips_sopc.sv - 5-stage MIPS32 integer core with instruction ROM
module mips_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] storage [0:31];

  // GPR write port; register 0 is never written
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) storage[i] <= 32'h0;
    end else if (we && waddr != 5'd0) begin
      storage[waddr] <= wdata;
    end
  end

  // read ports with write-through so WB results are visible in the same cycle
  always_comb begin
    rdata1 = storage[raddr1];
    rdata2 = storage[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = 32'h0;
    if (raddr2 == 5'd0) rdata2 = 32'h0;
  end
endmodule

module mips_rom #(
  parameter int ROM_DEPTH = 1024
) (
  mips_sopc_if.slave ibus
);
  localparam int AW = $clog2(ROM_DEPTH);

  logic [31:0] storage [0:ROM_DEPTH-1];
  logic [31:0] rdata;
  logic        unused_pc_lsbs;

  assign unused_pc_lsbs = &{1'b0, ibus.pc[1:0]};
  assign ibus.instr = rdata;

  // word-indexed read; fetches beyond the array return a nop
  always_comb begin
    rdata = 32'h0;
    if (ibus.pc[31:2] < 30'(ROM_DEPTH)) rdata = storage[ibus.pc[AW+1:2]];
  end
endmodule

module mips_core (
  input  logic       clock,
  input  logic       reset,
  mips_sopc_if.master ibus
);
  typedef enum logic [2:0] {
    ALU_OR, ALU_AND, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  logic [31:0] pc;
  logic [31:0] id_instr;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;
  logic [31:0] rf_rdata1, rf_rdata2, rs_val, rt_val;

  alu_op_t     id_op;
  logic [31:0] id_src1, id_src2;
  logic [4:0]  id_wd;
  logic        id_supported, id_wreg;

  alu_op_t     ex_op;
  logic [31:0] ex_src1, ex_src2, ex_result;
  logic [4:0]  ex_wd;
  logic        ex_wreg;

  logic [31:0] mem_wdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg;

  logic [31:0] wb_wdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;

  assign ibus.pc = pc;
  assign opcode  = id_instr[31:26];
  assign rs      = id_instr[25:21];
  assign rt      = id_instr[20:16];
  assign rd      = id_instr[15:11];
  assign sa      = id_instr[10:6];
  assign funct   = id_instr[5:0];
  assign imm     = id_instr[15:0];

  // fetch: PC advances one word per cycle and the fetched word enters IF/ID
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= 32'h0;
      id_instr <= 32'h0;
    end else begin
      pc       <= pc + 32'd4;
      id_instr <= ibus.instr;
    end
  end

  mips_regfile register (
    .clock  (clock),
    .reset  (reset),
    .raddr1 (rs),
    .rdata1 (rf_rdata1),
    .raddr2 (rt),
    .rdata2 (rf_rdata2),
    .we     (wb_wreg),
    .waddr  (wb_wd),
    .wdata  (wb_wdata)
  );

  // operand forwarding: youngest producer (EX) wins, then MEM, then WB
  always_comb begin
    rs_val = rf_rdata1;
    rt_val = rf_rdata2;
    if (rs != 5'd0) begin
      if (ex_wreg && ex_wd == rs)        rs_val = ex_result;
      else if (mem_wreg && mem_wd == rs) rs_val = mem_wdata;
      else if (wb_wreg && wb_wd == rs)   rs_val = wb_wdata;
    end
    if (rt != 5'd0) begin
      if (ex_wreg && ex_wd == rt)        rt_val = ex_result;
      else if (mem_wreg && mem_wd == rt) rt_val = mem_wdata;
      else if (wb_wreg && wb_wd == rt)   rt_val = wb_wdata;
    end
  end

  // decode: shifts carry the amount in src1 and the shifted value in src2
  always_comb begin
    id_op        = ALU_OR;
    id_src1      = 32'h0;
    id_src2      = 32'h0;
    id_wd        = rd;
    id_supported = 1'b0;
    case (opcode)
      6'b000000: begin
        id_supported = 1'b1;
        id_src1      = rs_val;
        id_src2      = rt_val;
        case (funct)
          6'b100100: id_op = ALU_AND;
          6'b100101: id_op = ALU_OR;
          6'b100110: id_op = ALU_XOR;
          6'b100111: id_op = ALU_NOR;
          6'b000000: begin id_op = ALU_SLL; id_src1 = {27'h0, sa}; end
          6'b000010: begin id_op = ALU_SRL; id_src1 = {27'h0, sa}; end
          6'b000011: begin id_op = ALU_SRA; id_src1 = {27'h0, sa}; end
          6'b000100: id_op = ALU_SLL;
          6'b000110: id_op = ALU_SRL;
          6'b000111: id_op = ALU_SRA;
          default:   id_supported = 1'b0;
        endcase
      end
      6'b001100: begin id_supported = 1'b1; id_op = ALU_AND; id_wd = rt; id_src1 = rs_val; id_src2 = {16'h0, imm}; end
      6'b001101: begin id_supported = 1'b1; id_op = ALU_OR;  id_wd = rt; id_src1 = rs_val; id_src2 = {16'h0, imm}; end
      6'b001110: begin id_supported = 1'b1; id_op = ALU_XOR; id_wd = rt; id_src1 = rs_val; id_src2 = {16'h0, imm}; end
      6'b001111: begin id_supported = 1'b1; id_op = ALU_OR;  id_wd = rt; id_src2 = {imm, 16'h0}; end
      default: id_supported = 1'b0;
    endcase
    id_wreg = id_supported && (id_wd != 5'd0);
  end

  // execute
  always_comb begin
    ex_result = 32'h0;
    case (ex_op)
      ALU_OR:  ex_result = ex_src1 | ex_src2;
      ALU_AND: ex_result = ex_src1 & ex_src2;
      ALU_XOR: ex_result = ex_src1 ^ ex_src2;
      ALU_NOR: ex_result = ~(ex_src1 | ex_src2);
      ALU_SLL: ex_result = ex_src2 << ex_src1[4:0];
      ALU_SRL: ex_result = ex_src2 >> ex_src1[4:0];
      ALU_SRA: ex_result = $signed(ex_src2) >>> ex_src1[4:0];
      default: ex_result = 32'h0;
    endcase
  end

  // ID/EX, EX/MEM and MEM/WB registers; reset leaves bubbles everywhere
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_op     <= ALU_OR;
      ex_src1   <= 32'h0;
      ex_src2   <= 32'h0;
      ex_wd     <= 5'd0;
      ex_wreg   <= 1'b0;
      mem_wdata <= 32'h0;
      mem_wd    <= 5'd0;
      mem_wreg  <= 1'b0;
      wb_wdata  <= 32'h0;
      wb_wd     <= 5'd0;
      wb_wreg   <= 1'b0;
    end else begin
      ex_op     <= id_op;
      ex_src1   <= id_src1;
      ex_src2   <= id_src2;
      ex_wd     <= id_wd;
      ex_wreg   <= id_wreg;
      mem_wdata <= ex_result;
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      wb_wdata  <= mem_wdata;
      wb_wd     <= mem_wd;
      wb_wreg   <= mem_wreg;
    end
  end
endmodule

module mips_sopc #(
  parameter int ROM_DEPTH = 1024
) (
  input logic clock,
  input logic reset
);
  mips_sopc_if ibus ();

  mips_core cpu (
    .clock (clock),
    .reset (reset),
    .ibus  (ibus.master)
  );

  mips_rom #(.ROM_DEPTH(ROM_DEPTH)) rom (
    .ibus (ibus.slave)
  );
endmodule

// File: tb/tb_mips_sopc.sv
// tb/tb_mips_sopc.sv - directed program bench for mips_sopc
module tb_mips_sopc;
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  mips_sopc #(.ROM_DEPTH(1024)) dut (
    .clock (clock),
    .reset (reset)
  );

  mips_sopc_if probe ();
  assign probe.pc    = dut.cpu.pc;
  assign probe.instr = dut.rom.rdata;

  typedef struct {
    int          edge_n;
    int          r;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] prog [0:17] = '{
    32'h3C020404, 32'h34420404, 32'h34070007, 32'h34050005,
    32'h34080008, 32'h0000000F, 32'h00021200, 32'h00E21004,
    32'h00021202, 32'h00A21006, 32'h00000000, 32'h00000000,
    32'h000214C0, 32'h00000040, 32'h00021403, 32'h01021007,
    32'h34000001, 32'h34031234
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // runs 22 edges after reset release and checks the table at each edge
  task automatic run_program(input string tag);
    for (int e = 1; e <= 22; e++) begin
      @(posedge clock);
      #1;
      check($sformatf("%s_pc_e%0d", tag, e), probe.pc, 32'(4 * e));
      foreach (vecs[i]) begin
        if (vecs[i].edge_n == e)
          check($sformatf("%s_e%0d_r%0d", tag, e, vecs[i].r),
                dut.cpu.register.storage[vecs[i].r], vecs[i].exp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{4, 2, 32'h00000000});
    vecs.push_back('{4, 7, 32'h00000000});
    vecs.push_back('{4, 5, 32'h00000000});
    vecs.push_back('{4, 8, 32'h00000000});
    vecs.push_back('{5, 2, 32'h04040000});
    vecs.push_back('{6, 2, 32'h04040404});
    vecs.push_back('{7, 7, 32'h00000007});
    vecs.push_back('{8, 5, 32'h00000005});
    vecs.push_back('{9, 8, 32'h00000008});
    vecs.push_back('{10, 2, 32'h04040404});
    vecs.push_back('{10, 7, 32'h00000007});
    vecs.push_back('{10, 5, 32'h00000005});
    vecs.push_back('{10, 8, 32'h00000008});
    vecs.push_back('{11, 2, 32'h04040400});
    vecs.push_back('{12, 2, 32'h02020000});
    vecs.push_back('{13, 2, 32'h00020200});
    vecs.push_back('{14, 2, 32'h00001010});
    vecs.push_back('{15, 2, 32'h00001010});
    vecs.push_back('{16, 2, 32'h00001010});
    vecs.push_back('{17, 2, 32'h80800000});
    vecs.push_back('{18, 2, 32'h80800000});
    vecs.push_back('{19, 2, 32'hffff8080});
    vecs.push_back('{20, 2, 32'hffffff80});
    vecs.push_back('{21, 0, 32'h00000000});
    vecs.push_back('{22, 0, 32'h00000000});
    vecs.push_back('{22, 3, 32'h00001234});

    for (int i = 0; i < 1024; i++) dut.rom.storage[i] = 32'h0;
    for (int i = 0; i < 18; i++) dut.rom.storage[i] = prog[i];

    // power-on reset held for 10 cycles
    reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("reset_pc", probe.pc, 32'h0);
    check("reset_r2", dut.cpu.register.storage[2], 32'h0);
    check("reset_wb_wreg", {31'h0, dut.cpu.wb_wreg}, 32'h0);
    reset = 1'b0;
    run_program("run1");

    // run off the end of the ROM: fetches must read as nop, not alias
    for (int c = 0; c < 2000 && probe.pc != 32'd4096; c++) begin
      @(posedge clock);
      #1;
    end
    check("oob_pc_reached", probe.pc, 32'd4096);
    check("oob_instr_nop", probe.instr, 32'h0);
    check("oob_r2_kept", dut.cpu.register.storage[2], 32'hffffff80);

    // restart, then assert reset while the program is in flight
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("mid_r7_before", dut.cpu.register.storage[7], 32'h7);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid_pc", probe.pc, 32'h0);
    for (int r = 0; r < 32; r++)
      check($sformatf("mid_gpr%0d", r), dut.cpu.register.storage[r], 32'h0);
    check("mid_squash", {29'h0, dut.cpu.ex_wreg, dut.cpu.mem_wreg, dut.cpu.wb_wreg}, 32'h0);
    reset = 1'b0;
    run_program("run2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_sopc.md
# mips_sopc

Minimal system-on-chip top: a 5-stage pipelined MIPS32 integer core plus a word-addressed instruction ROM, driven by one clock and one reset. It is the unit instantiated by the instruction-level regression benches. Benches load the ROM and inspect architectural registers directly through hierarchy. The only external pins are clock and reset.

## Interface
- ROM_DEPTH, 1024, instruction ROM depth in 32-bit words (minimum 16).
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; all state updates on the rising edge of clock.
- Required hierarchy, which benches access directly:
  - Instance `cpu` (core) containing instance `register` with array `storage[0:31]` of 32-bit words (GPRs).
  - Instance `rom` with array `storage[0:ROM_DEPTH-1]` of 32-bit words, loadable by `$readmemh`.

## Operation
- ROM: combinational read; word index = pc[31:2].
  - Index ≥ ROM_DEPTH returns 32'h0 (nop).
  - Holds whatever the bench loads; never written by hardware.
- Core pipeline: IF → ID → EX → MEM → WB, one instruction issued per cycle, no stalls needed for the supported set.
  - PC resets to 0 and increments by 4 each cycle.
- Register file: 32×32 GPRs, two read ports, one write port (written at the end of WB).
  - Register 0 reads 0 and is never written.
  - Read of a register being written in the same cycle returns the new value (write-through bypass).
  - Reset clears all GPRs to 0.
- Forwarding: an ID-stage operand takes the value from EX (highest priority), then MEM, then WB, whenever that stage writes the same non-zero register. Back-to-back dependent instructions therefore see correct values.
- Supported instructions (anything else executes as a no-op with no register write):
  - lui rt,imm: rt = {imm,16'h0}.
  - ori rt,rs,imm: rt = rs | zero-extended imm.
  - andi, xori: same form as ori, with zero-extended imm.
  - and, or, xor, nor rd,rs,rt.
  - sll/srl/sra rd,rt,sa: shift amount from instr[10:6].
  - sllv/srlv/srav rd,rt,rs: shift amount = rs[4:0].
  - sra/srav replicate rt[31]; srl/srlv fill with zeros. Results are truncated to 32 bits.
  - nop (32'h0), ssnop (32'h00000040), sync (32'h0000000F): no state change beyond PC advance.
- Writes to rd/rt equal to 0 are discarded.

## Timing
- While reset is high: pc=0, all pipeline registers hold a bubble (no write-enable), GPRs = 0.
- First rising edge with reset low latches the instruction at address 0 into IF/ID.
- Latency: the instruction at word k writes its GPR on the (k+5)-th rising edge after reset deasserts. The value is readable by hierarchy immediately after that edge.
- Throughput: one retirement per cycle; consecutive results appear on consecutive edges.
- Reset asserted mid-program: on that edge pc returns to 0, in-flight instructions are squashed (no writes), and GPRs clear.

## Test plan
Load the 16-word shift program: lui $2,0x0404; ori $2,$2,0x0404; ori $7,$0,7; ori $5,$0,5; ori $8,$0,8; sync; sll $2,$2,8; sllv $2,$2,$7; srl $2,$2,8; srlv $2,$2,$5; nop; nop; sll $2,$2,19; ssnop; sra $2,$2,16; srav $2,$2,$8. Hold reset 10 cycles, release, sample 1 ns after each rising edge from the 5th onward.
- Dependent immediates with forwarding: $2=04040000 after edge 5, then 04040404; $7=7, $5=5, $8=8 on the next three edges.
- sync no-op: all four registers unchanged (04040404/7/5/8).
- Logical shifts: $2 = 04040400, then 02020000, 00020200, 00001010 on successive edges.
- nop/ssnop: $2 holds 00001010 for two edges. After sll by 19 it is 80800000, and it holds 80800000 across ssnop.
- Arithmetic shifts: $2 = ffff8080, then ffffff80.
- Writes to $0 are discarded: write to $0 (e.g. ori $0,$0,1) → $0 reads 0.
- Reset mid-program: assert reset mid-program → GPRs read 0, and the program replays from address 0 with identical results.
